// File: rtl/csa_accum_pipe.sv
// Multi-beat carry-save accumulator: beats fold into a redundant sum/carry pair,
// resolved by one carry-propagate add per packet. Optional beat checker: CSA_BEATCHK_EN.
module csa_accum_pipe #(
  parameter int NUM_OPS   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4,
  localparam int OUT_W    = WIDTH + $clog2(NUM_OPS * MAX_BEATS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [OUT_W-1:0] sum_reg, carry_reg;
  logic [OUT_W-1:0] base_sum, base_carry;
  logic [OUT_W-1:0] csa_sum, csa_carry;
  logic [OUT_W-1:0] chain_s, chain_c, chain_t;
  logic [OUT_W-1:0] ops [NUM_OPS];
  logic             accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : gen_ops
      assign ops[gi] = OUT_W'(in_data[gi*WIDTH +: WIDTH]);
    end
  endgenerate

  // Any beat accepted outside ACCUM opens a fresh packet, so the tree starts from zero.
  assign base_sum   = (state_reg == ACCUM) ? sum_reg   : '0;
  assign base_carry = (state_reg == ACCUM) ? carry_reg : '0;
  assign accept     = in_valid & in_ready;

  // Linear chain of 3:2 compressors; carries shift left with the MSB dropped (mod 2^OUT_W).
  always_comb begin
    chain_s = base_sum;
    chain_c = base_carry;
    chain_t = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      chain_t = chain_s ^ chain_c ^ ops[k];
      chain_c = ((chain_s & chain_c) | (chain_s & ops[k]) | (chain_c & ops[k])) << 1;
      chain_s = chain_t;
    end
    csa_sum   = chain_s;
    csa_carry = chain_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) state_next = in_last ? RESOLVE : ACCUM;
      end
      RESOLVE: state_next = HOLD;
      HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) state_next = in_last ? RESOLVE : ACCUM;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg   <= '0;
      carry_reg <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        sum_reg   <= csa_sum;
        carry_reg <= csa_carry;
      end
      if (state_reg == RESOLVE) begin
        out_data  <= sum_reg + carry_reg;
        out_valid <= 1'b1;
      end else if (state_reg == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CSA_BEATCHK_EN
  localparam int CNT_W = $clog2(MAX_BEATS) + 2;
  logic [CNT_W-1:0] beat_cnt;

  // Saturating so a runaway packet still reports the violation rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      out_err  <= 1'b0;
    end else begin
      if (accept) begin
        if (state_reg != ACCUM)   beat_cnt <= CNT_W'(1);
        else if (beat_cnt != '1)  beat_cnt <= beat_cnt + 1'b1;
      end
      if (state_reg == RESOLVE) out_err <= (beat_cnt > CNT_W'(MAX_BEATS));
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule
